// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth carry-save accumulator.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Booth digit as sign plus one-hot magnitude; sign with zero magnitude is still zero.
    typedef struct packed {
        logic sign;
        logic one;
        logic two;
    } booth_digit_t;

    localparam int BOOTH_WIDTH = 16;

    function automatic int step_width(input int width);
        return (width / 2 > 1) ? $clog2(width / 2) : 1;
    endfunction

    localparam int STEP_W = step_width(BOOTH_WIDTH);

    function automatic booth_digit_t booth_encode(input logic [2:0] window);
        booth_digit_t digit;
        digit.sign = window[2];
        digit.one  = window[1] ^ window[0];
        digit.two  = (window == 3'b011) || (window == 3'b100);
        return digit;
    endfunction

endpackage

// File: rtl/Compressor_3_2.sv
// Single full-adder style 3:2 compressor cell.
module Compressor_3_2 (
    input  logic i0,
    input  logic i1,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = i0 ^ i1 ^ ci;
    assign co = (i0 & i1) | (i0 & ci) | (i1 & ci);

endmodule

// File: rtl/csa_row_3_2.sv
// Combinational row of 3:2 compressors; carry is returned already weighted one bit up.
module csa_row_3_2 #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] c,
    output logic [N-1:0] sum,
    output logic [N-1:0] carry
);

    logic [N-1:0] co;
    logic         co_msb_unused;

    for (genvar i = 0; i < N; i++) begin : g_cell
        Compressor_3_2 u_cell (
            .i0 (a[i]),
            .i1 (b[i]),
            .ci (c[i]),
            .s  (sum[i]),
            .co (co[i])
        );
    end

    // Top carry falls outside the modulus and is dropped.
    assign co_msb_unused = co[N-1];
    assign carry         = {co[N-2:0], 1'b0};

endmodule

// File: rtl/booth_r4_csa_accumulator.sv
// Sequential radix-4 Booth multiplier front end producing a carry-save product.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// ACCUM | one Booth partial product folded into S/C per cycle
// DONE  | S/C frozen and presented, waiting for out_ready
module booth_r4_csa_accumulator
    import booth_pkg::*;
#(
    parameter int WIDTH = BOOTH_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_sum,
    output logic [2*WIDTH-1:0]   out_carry
);

    localparam int PW = 2 * WIDTH;
    localparam int K_W = step_width(WIDTH);
    localparam logic [K_W-1:0] K_LAST = K_W'(WIDTH / 2 - 1);

    state_t         state;
    state_t         state_nxt;
    logic [PW-1:0]  a_ext;
    logic [WIDTH:0] bx;
    logic [K_W-1:0] k;
    logic [PW-1:0]  s_reg;
    logic [PW-1:0]  c_reg;

    logic [2:0]     window;
    booth_digit_t   digit;
    logic [PW-1:0]  mag;
    logic [PW-1:0]  pp_base;
    logic [PW-1:0]  pp;
    logic [PW-1:0]  row_sum;
    logic [PW-1:0]  row_carry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = ACCUM;
            ACCUM:   if (k == K_LAST) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Partial product is formed exactly, including the two's complement negation.
    always_comb begin
        window  = bx[{k, 1'b0} +: 3];
        digit   = booth_encode(window);
        mag     = '0;
        if (digit.two) begin
            mag = a_ext << 1;
        end else if (digit.one) begin
            mag = a_ext;
        end
        pp_base = digit.sign ? (~mag + PW'(1)) : mag;
        pp      = pp_base << {k, 1'b0};
    end

    csa_row_3_2 #(
        .N (PW)
    ) u_csa_row (
        .a     (s_reg),
        .b     (pp),
        .c     (c_reg),
        .sum   (row_sum),
        .carry (row_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_ext <= '0;
            bx    <= '0;
            k     <= '0;
            s_reg <= '0;
            c_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_ext <= {{WIDTH{multiplicand[WIDTH-1]}}, multiplicand};
                        bx    <= {multiplier, 1'b0};
                        k     <= '0;
                        s_reg <= '0;
                        c_reg <= '0;
                    end
                end
                ACCUM: begin
                    s_reg <= row_sum;
                    c_reg <= row_carry;
                    k     <= (k == K_LAST) ? '0 : k + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign out_sum   = s_reg;
    assign out_carry = c_reg;

endmodule

// File: tb/tb_booth_r4_csa_accumulator.sv
// Self-checking bench: directed vectors, backpressure, mid-op reset and randomized traffic.
module tb_booth_r4_csa_accumulator;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  multiplicand;
    logic [W-1:0]  multiplier;
    logic          out_valid;
    logic          out_ready;
    logic [2*W-1:0] out_sum;
    logic [2*W-1:0] out_carry;

    int checks = 0;
    int errors = 0;

    booth_r4_csa_accumulator #(
        .WIDTH (W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_carry    (out_carry)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [W-1:0] a;
        logic signed [W-1:0] b;
        logic [2*W-1:0]      exp;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [2*W-1:0] model(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
        longint p;
        p = longint'(a) * longint'(b);
        return p[2*W-1:0];
    endfunction

    function automatic logic [2*W-1:0] cs_total();
        return out_sum + out_carry;
    endfunction

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic run_op(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                          input logic [2*W-1:0] exp, input string tag);
        int cyc;
        multiplicand = a;
        multiplier   = b;
        in_valid     = 1'b1;
        out_ready    = 1'b0;
        chk({tag, "_in_ready"}, 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid(cyc);
        chk({tag, "_latency"}, 64'(cyc), 64'(W / 2));
        chk({tag, "_result"}, 64'(cs_total()), 64'(exp));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_after_handshake"}, 64'({out_valid, in_ready}), 64'(2'b01));
    endtask

    initial begin
        int cyc;
        int seen;
        logic [2*W-1:0] hold_s;
        logic [2*W-1:0] hold_c;
        logic [2*W-1:0] q[$];
        int got_n;
        int sent;
        int cyc_n;
        int last_acc;
        bit acc;

        vecs[0] = '{a: 16'sd3,      b: 16'sd5,      exp: 32'h0000000F};
        vecs[1] = '{a: -16'sd32768, b: -16'sd32768, exp: 32'h40000000};
        vecs[2] = '{a: -16'sd1,     b: 16'sd32767,  exp: 32'hFFFF8001};
        vecs[3] = '{a: 16'sd32767,  b: 16'sd32767,  exp: 32'h3FFF0001};
        vecs[4] = '{a: -16'sd32768, b: 16'sd32767,  exp: 32'hC0008000};
        vecs[5] = '{a: 16'sd0,      b: -16'sd1234,  exp: 32'h00000000};

        rst          = 1'b1;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'(1));
        chk("reset_out_valid", 64'(out_valid), 64'(0));
        chk("reset_out_sum", 64'(out_sum), 64'(0));
        chk("reset_out_carry", 64'(out_carry), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Backpressure with in_valid held high throughout
        multiplicand = 16'sd123;
        multiplier   = -16'sd456;
        in_valid     = 1'b1;
        out_ready    = 1'b0;
        @(posedge clk);
        #1;
        wait_valid(cyc);
        chk("bp_latency", 64'(cyc), 64'(W / 2));
        chk("bp_result", 64'(cs_total()), 64'(model(16'sd123, -16'sd456)));
        hold_s = out_sum;
        hold_c = out_carry;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_sum_stable", 64'(out_sum), 64'(hold_s));
            chk("bp_carry_stable", 64'(out_carry), 64'(hold_c));
            chk("bp_in_ready_low", 64'(in_ready), 64'(0));
            chk("bp_out_valid_high", 64'(out_valid), 64'(1));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_in_ready_after", 64'(in_ready), 64'(1));
        chk("bp_out_valid_after", 64'(out_valid), 64'(0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid(cyc);
        chk("bp_second_latency", 64'(cyc), 64'(W / 2));
        chk("bp_second_result", 64'(cs_total()), 64'(model(16'sd123, -16'sd456)));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset asserted during the fourth compression step
        multiplicand = 16'sd1000;
        multiplier   = -16'sd3;
        in_valid     = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_out_valid", 64'(out_valid), 64'(0));
        chk("rst_mid_in_ready", 64'(in_ready), 64'(1));
        chk("rst_mid_out_sum", 64'(out_sum), 64'(0));
        chk("rst_mid_out_carry", 64'(out_carry), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("rst_no_result", 64'(seen), 64'(0));
        run_op(16'sd7, -16'sd9, 32'hFFFFFFC1, "post_reset");

        // Randomized traffic against the arithmetic model
        got_n        = 0;
        sent         = 0;
        cyc_n        = 0;
        last_acc     = 0;
        acc          = 1'b0;
        multiplicand = 16'($urandom);
        multiplier   = 16'($urandom);
        in_valid     = 1'b1;
        while (got_n < 1000 && cyc_n < 60000) begin
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("rand_unexpected_result", 64'(1), 64'(0));
                end else begin
                    chk("rand_result", 64'(cs_total()), 64'(q.pop_front()));
                end
                got_n++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(multiplicand, multiplier));
                if (sent > 0) begin
                    chk("rand_interval_ge10", 64'((cyc_n - last_acc) >= 10), 64'(1));
                end
                last_acc = cyc_n;
                sent++;
                acc = 1'b1;
            end
            @(posedge clk);
            #1;
            cyc_n++;
            if (acc) begin
                multiplicand = 16'($urandom);
                multiplier   = 16'($urandom);
                in_valid     = (sent < 1000);
                acc          = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("rand_result_count", 64'(got_n), 64'(1000));
        chk("rand_queue_empty", 64'(q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
